// File: rtl/kds_pkg.sv
// Shared constants and types for the kernel data shifter (KDS) loader.
package kds_pkg;

  localparam int KDS_NB_GROUPS       = 12;
  localparam int KDS_LANES           = 3;
  localparam int KDS_LOG2_RING_DEPTH = 3;
  localparam int KDS_IO_DATA_WIDTH   = 16;

  typedef struct packed {
    logic [KDS_IO_DATA_WIDTH-1:0] d1;
    logic [KDS_IO_DATA_WIDTH-1:0] d2;
    logic [KDS_IO_DATA_WIDTH-1:0] d3;
  } kds_triple_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } kds_ld_state_t;

endpackage

// File: rtl/kds_stage_buf.sv
// Staging register file for one ring's worth of triples: one write port,
// asynchronous read so the ring position maps straight to the lane outputs.
module kds_stage_buf
  import kds_pkg::*;
#(
  parameter int DW = KDS_IO_DATA_WIDTH,
  parameter int AW = KDS_LOG2_RING_DEPTH
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [KDS_LANES*DW-1:0] wdata_i,
  input  logic [AW-1:0]           raddr_i,
  output logic [KDS_LANES*DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [KDS_LANES*DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kds_loader.sv
// KDS producer: stages one ring of weight triples per group, then rewrites
// that group's rings position-aligned using the free-running ring phase.
module kds_loader
  import kds_pkg::*;
#(
  parameter int IO_DATA_WIDTH   = KDS_IO_DATA_WIDTH,
  parameter int NB_GROUPS       = KDS_NB_GROUPS,
  parameter int LOG2_RING_DEPTH = KDS_LOG2_RING_DEPTH
) (
  input  logic                             clk,
  input  logic                             arst_n_in,
  input  logic                             start,
  input  logic [$clog2(NB_GROUPS)-1:0]     first_group,
  input  logic [$clog2(NB_GROUPS+1)-1:0]   nb_groups,
  input  logic [IO_DATA_WIDTH-1:0]         in_d1,
  input  logic [IO_DATA_WIDTH-1:0]         in_d2,
  input  logic [IO_DATA_WIDTH-1:0]         in_d3,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [IO_DATA_WIDTH-1:0]         v_1,
  output logic [IO_DATA_WIDTH-1:0]         v_2,
  output logic [IO_DATA_WIDTH-1:0]         v_3,
  output logic [NB_GROUPS-1:0]             LE_select,
  output logic [LOG2_RING_DEPTH-1:0]       ring_phase,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int DW         = IO_DATA_WIDTH;
  localparam int GW         = $clog2(NB_GROUPS);
  localparam int CW         = $clog2(NB_GROUPS + 1);
  localparam int PW         = LOG2_RING_DEPTH;
  localparam int FW         = LOG2_RING_DEPTH + 1;
  localparam int RING_DEPTH = 1 << LOG2_RING_DEPTH;

  localparam logic [GW-1:0] LAST_GROUP = GW'(NB_GROUPS - 1);
  localparam logic [CW-1:0] MAX_GROUPS = CW'(NB_GROUPS);
  localparam logic [FW-1:0] FILL_LAST  = FW'(RING_DEPTH - 1);
  localparam logic [PW-1:0] PHASE_LAST = '1;

  kds_ld_state_t   state_q, state_d;
  logic [PW-1:0]   phase_q;
  logic [FW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [PW-1:0]   drv_cnt_q, drv_cnt_d;
  logic [GW-1:0]   cur_group_q, cur_group_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            err_q, err_d;
  logic            buf_we;
  logic            driving;
  logic [3*DW-1:0] buf_rdata;

  kds_stage_buf #(
    .DW (DW),
    .AW (PW)
  ) u_stage_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (fill_cnt_q[PW-1:0]),
    .wdata_i ({in_d1, in_d2, in_d3}),
    .raddr_i (phase_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drv_cnt_d   = drv_cnt_q;
    cur_group_d = cur_group_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    buf_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((first_group > LAST_GROUP) || (nb_groups > MAX_GROUPS)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (nb_groups == '0) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else begin
            state_d     = FILL;
            cur_group_d = first_group;
            remaining_d = nb_groups;
            fill_cnt_d  = '0;
          end
        end
      end
      FILL: begin
        if (in_valid) begin
          buf_we     = 1'b1;
          fill_cnt_d = fill_cnt_q + FW'(1);
          if (fill_cnt_q == FILL_LAST) begin
            state_d   = DRIVE;
            drv_cnt_d = '0;
          end
        end
      end
      DRIVE: begin
        drv_cnt_d = drv_cnt_q + PW'(1);
        if (drv_cnt_q == PHASE_LAST) begin
          remaining_d = remaining_q - CW'(1);
          fill_cnt_d  = '0;
          if (remaining_q == CW'(1)) begin
            state_d = DONE;
          end else begin
            state_d     = FILL;
            cur_group_d = (cur_group_q == LAST_GROUP) ? '0 : cur_group_q + GW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // ring_phase must free-run from reset so it tracks the KDS ring positions.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      fill_cnt_q  <= '0;
      drv_cnt_q   <= '0;
      cur_group_q <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_q + PW'(1);
      fill_cnt_q  <= fill_cnt_d;
      drv_cnt_q   <= drv_cnt_d;
      cur_group_q <= cur_group_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  assign driving    = (state_q == DRIVE);
  assign in_ready   = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign ring_phase = phase_q;

  for (genvar gi = 0; gi < NB_GROUPS; gi++) begin : g_le
    assign LE_select[gi] = driving && (cur_group_q == GW'(gi));
  end

  assign v_1 = driving ? buf_rdata[3*DW-1:2*DW] : '0;
  assign v_2 = driving ? buf_rdata[2*DW-1:DW]   : '0;
  assign v_3 = driving ? buf_rdata[DW-1:0]      : '0;

endmodule

// File: doc/kds_loader.md
# kds_loader

Producer side of the kernel data shifter (KDS) interface. Accepts kernel-weight triples from an upstream valid/ready stream and buffers one full ring (RING_DEPTH triples) per group. It then drives `v_1/v_2/v_3` and a one-hot `LE_select` so that each group's three recirculating rings are overwritten position-aligned. It sits between the external-memory reader and the KDS and shares its clock and reset.

## Interface
- `IO_DATA_WIDTH`, 16: width of each lane word.
- `NB_GROUPS`, 12: number of KDS groups; equals the `LE_select` width.
- `LOG2_RING_DEPTH`, 3: log2 of the per-group ring depth. `RING_DEPTH` = 8.
- `clk`  in  1  system clock.
- `arst_n_in`  in  1  asynchronous reset, active low. One clock; reset is asynchronous and active-low.
- `start`  in  1  command pulse; sampled only in IDLE.
- `first_group`  in  $clog2(NB_GROUPS)  first group to load.
- `nb_groups`  in  $clog2(NB_GROUPS+1)  number of consecutive groups to load.
- `in_d1`, `in_d2`, `in_d3`  in  IO_DATA_WIDTH each  upstream triple.
- `in_valid`  in  1  upstream triple valid.
- `in_ready`  out  1  loader accepts a triple this cycle.
- `v_1`, `v_2`, `v_3`  out  IO_DATA_WIDTH each  KDS lane data.
- `LE_select`  out  NB_GROUPS  one-hot load enable to the KDS.
- `ring_phase`  out  LOG2_RING_DEPTH  current ring position.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at the end of a command.
- `err`  out  1  qualifies `done`; set when the command was rejected.

## Operation
- `ring_phase` is a free-running counter that increments modulo RING_DEPTH every cycle from reset, independent of the FSM. It stays in lockstep with the KDS rings because both share `arst_n_in`.
- The staging buffer holds RING_DEPTH triples and is written in arrival order at index `fill_cnt`.
- FSM states:
  - IDLE: `start` → FILL. Two cases instead go to DONE with `err`=1: `first_group` ≥ NB_GROUPS, or `nb_groups` > NB_GROUPS. The case `nb_groups`==0 goes to DONE with `err`=0.
  - FILL: `in_ready`=1. Each `in_valid & in_ready` writes the staging buffer and increments `fill_cnt`. The beat that makes `fill_cnt` reach RING_DEPTH moves to DRIVE; `in_ready` is 0 in the following cycle.
  - DRIVE: exactly RING_DEPTH cycles. `LE_select` = one-hot(`cur_group`) and `v_k` = staging[`ring_phase`].k, so ring position p always receives triple p whatever phase DRIVE started at. At the end, `remaining` is decremented. If `remaining` is nonzero, `cur_group` advances modulo NB_GROUPS (11 → 0) and the FSM returns to FILL; otherwise it goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Outside DRIVE, `LE_select`=0 and `v_1..v_3`=0.
- `start` outside IDLE is ignored. `in_valid` outside FILL is not consumed.
- Upstream gaps during FILL only lengthen FILL; DRIVE is never interrupted.

## Timing
- Reset values: state IDLE, `ring_phase`=0, `fill_cnt`=0, `in_ready`=0, `LE_select`=0, `v_*`=0, `busy`=0, `done`=0, `err`=0.
- Outputs are functions of registered state only; there is no combinational path from inputs to outputs.
- A `start` accepted at cycle t gives FILL at t+1.
- With `in_valid` held high, FILL lasts 8 cycles and DRIVE lasts 8 cycles, so one group takes 16 cycles. `done` asserts at t+1+16·nb_groups.
- Reset asserted mid-FILL or mid-DRIVE returns everything to reset values immediately. The staging contents are discarded, and the partially overwritten KDS ring is the responsibility of the caller.
- Staging width: 3·IO_DATA_WIDTH × RING_DEPTH. No arithmetic is applied to the data.

## Structure
- Package `kds_pkg` holds:
  - constants `KDS_NB_GROUPS`=12, `KDS_LANES`=3, `KDS_LOG2_RING_DEPTH`=3;
  - typedef `kds_triple_t` (three lane words);
  - enum `kds_ld_state_t` {IDLE, FILL, DRIVE, DONE}.
- Sub-module `kds_stage_buf` is the RING_DEPTH-entry triple register file: write port at `fill_cnt`, asynchronous read at `ring_phase`.

## Test plan
- Reset check: hold `arst_n_in` low, then release → all outputs at reset values and `ring_phase` counts 0,1,…,7,0.
- Single-group load: `start`, `first_group`=2, `nb_groups`=1, triples (k, 100+k, 200+k) for k=0..7 with no gaps → 8 DRIVE cycles with `LE_select`=12'h004 and `v_1`=`ring_phase`; `done` at t+17.
- Backpressure: `in_valid` low on alternate cycles → FILL stretches to 15 cycles; DRIVE content is unchanged; no beat is lost or duplicated.
- Wrap-around: `first_group`=11, `nb_groups`=2 → DRIVE phases show `LE_select`=12'h800 then 12'h001; `done` at t+33.
- Edge commands:
  - `nb_groups`=0 → `done`=1, `err`=0 at t+1, no DRIVE;
  - `first_group`=12 → `done`=1, `err`=1;
  - a `start` pulse during DRIVE → ignored.
- Reset mid-DRIVE (4th cycle) → `LE_select`=0 immediately, FSM in IDLE, a fresh command completes normally.
